// File: rtl/microcode_loader_pkg.sv
// Shared types and default geometry for the microcode loader and microcode memory.
package microcode_loader_pkg;

  localparam int unsigned DEFAULT_WORDS  = 64;
  localparam int unsigned DEFAULT_ADDR_W = $clog2(DEFAULT_WORDS);
  localparam int unsigned DEFAULT_DATA_W = 19;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 3;
  localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned WORD_W1        = WORD_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } loader_state_t;

  // Bits of a received 24-bit word above the control field; they must arrive as zero.
  function automatic logic [WORD_W-1:0] reserved_mask(input int unsigned data_w);
    logic [WORD_W1-1:0] ones;
    ones = (WORD_W1'(1) << data_w) - WORD_W1'(1);
    return ~WORD_W'(ones);
  endfunction

endpackage

// File: rtl/microcode_loader_if.sv
// Byte stream, microcode write port and status bundle between the loader and its host.
interface microcode_loader_if #(
  parameter int unsigned ADDR_W = microcode_loader_pkg::DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = microcode_loader_pkg::DEFAULT_DATA_W
) ();

  logic              load_start_i;
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic              microcode_we_o;
  logic [ADDR_W-1:0] microcode_write_addr_o;
  logic [DATA_W-1:0] microcode_write_data_o;
  logic              core_rst_o;
  logic              busy_o;
  logic              done_o;
  logic              error_o;

  // Host side: starts loads, supplies the stream, consumes writes and status.
  modport master (
    output load_start_i, byte_valid_i, byte_data_i,
    input  byte_ready_o, microcode_we_o, microcode_write_addr_o, microcode_write_data_o,
    input  core_rst_o, busy_o, done_o, error_o
  );

  // Loader side.
  modport slave (
    input  load_start_i, byte_valid_i, byte_data_i,
    output byte_ready_o, microcode_we_o, microcode_write_addr_o, microcode_write_data_o,
    output core_rst_o, busy_o, done_o, error_o
  );

endinterface

// File: rtl/microcode_loader_byte_word_assembler.sv
// Packs little-endian stream bytes into 24-bit words and keeps a running XOR of every data byte.
module byte_word_assembler
  import microcode_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              accept,
  input  logic              clear,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_complete_c,
  output logic [WORD_W-1:0] word_c,
  output logic [BYTE_W-1:0] checksum
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]        idx_q;
  logic [WORD_W-1:0] lanes_q;
  logic [BYTE_W-1:0] sum_q;

  // Lane register, byte index and running checksum.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      idx_q   <= 2'd0;
      lanes_q <= '0;
      sum_q   <= '0;
    end else if (accept) begin
      case (idx_q)
        2'd0:    lanes_q[BYTE_W-1:0]          <= byte_data;
        2'd1:    lanes_q[2*BYTE_W-1:BYTE_W]   <= byte_data;
        default: lanes_q[3*BYTE_W-1:2*BYTE_W] <= byte_data;
      endcase
      sum_q <= sum_q ^ byte_data;
      idx_q <= (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
    end
  end

  // The word is presented with the incoming byte already in place so the FSM can act on the completing edge.
  always_comb begin
    word_c = lanes_q;
    case (idx_q)
      2'd0:    word_c[BYTE_W-1:0]          = byte_data;
      2'd1:    word_c[2*BYTE_W-1:BYTE_W]   = byte_data;
      default: word_c[3*BYTE_W-1:2*BYTE_W] = byte_data;
    endcase
  end

  assign word_complete_c = accept && (idx_q == LAST_IDX);
  assign checksum        = sum_q;

endmodule

// File: rtl/microcode_loader.sv
// Boot-time microcode loader: streams a checksummed image into microcode memory and
// holds the core in reset until a verified image is resident.
module microcode_loader
  import microcode_loader_pkg::*;
#(
  parameter int unsigned WORDS  = DEFAULT_WORDS,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  microcode_loader_if.slave bus
);

  localparam logic [WORD_W-1:0] RSVD_MASK = reserved_mask(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic ready_q, we_q, core_rst_q, busy_q, done_q, error_q;
  logic ready_d, we_d, core_rst_d, busy_d, done_d, error_d;

  logic              byte_accept_c;
  logic              asm_accept_c;
  logic              start_c;
  logic              word_complete_c;
  logic              rsvd_bad_c;
  logic [WORD_W-1:0] word_c;
  logic [BYTE_W-1:0] checksum;

  assign byte_accept_c = bus.byte_valid_i && ready_q;
  assign asm_accept_c  = byte_accept_c && (state_q == RECV);
  assign start_c       = bus.load_start_i && (state_q inside {IDLE, DONE, ERROR});
  assign rsvd_bad_c    = |(word_c & RSVD_MASK);

  byte_word_assembler u_asm (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .accept          (asm_accept_c),
    .clear           (start_c),
    .byte_data       (bus.byte_data_i),
    .word_complete_c (word_complete_c),
    .word_c          (word_c),
    .checksum        (checksum)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start_c) state_d = RECV;
      RECV:              if (word_complete_c) state_d = rsvd_bad_c ? ERROR : WRITE;
      WRITE:             state_d = (addr_q == LAST_ADDR) ? CHECK : RECV;
      CHECK: begin
        if (byte_accept_c) state_d = (bus.byte_data_i == checksum) ? DONE : ERROR;
      end
      default:           state_d = IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered below so outputs track the state register.
  always_comb begin
    ready_d    = 1'b0;
    we_d       = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    core_rst_d = 1'b1;
    case (state_d)
      RECV:    begin ready_d = 1'b1; busy_d = 1'b1; end
      WRITE:   begin we_d    = 1'b1; busy_d = 1'b1; end
      CHECK:   begin ready_d = 1'b1; busy_d = 1'b1; end
      DONE:    begin done_d  = 1'b1; core_rst_d = 1'b0; end
      ERROR:   error_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      we_q       <= we_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Write address advances only when leaving WRITE for another word; the last word never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (start_c) begin
        addr_q <= '0;
      end else if (state_q == WRITE && state_d == RECV) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      if (state_q == RECV && state_d == WRITE) begin
        data_q <= word_c[DATA_W-1:0];
      end
    end
  end

  assign bus.byte_ready_o           = ready_q;
  assign bus.microcode_we_o         = we_q;
  assign bus.microcode_write_addr_o = addr_q;
  assign bus.microcode_write_data_o = data_q;
  assign bus.core_rst_o             = core_rst_q;
  assign bus.busy_o                 = busy_q;
  assign bus.done_o                 = done_q;
  assign bus.error_o                = error_q;

endmodule

// File: tb/tb_microcode_loader.sv
// Directed self-checking bench for microcode_loader.
module tb_microcode_loader;

  localparam int unsigned WORDS  = 64;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 19;

  logic clk = 1'b0;
  logic rst;

  microcode_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  microcode_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int start_edge = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [DATA_W-1:0] wr_data_q[$];

  // Write-port monitor: one log entry per cycle with we high.
  always @(negedge clk) begin
    if (bus.microcode_we_o === 1'b1) begin
      wr_addr_q.push_back(bus.microcode_write_addr_o);
      wr_data_q.push_back(bus.microcode_write_data_o);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] img_word(input int k);
    return 24'((k * 32'h1111) & 32'h7FFFF);
  endfunction

  function automatic logic [7:0] img_checksum();
    logic [7:0] s;
    logic [23:0] w;
    s = 8'h00;
    for (int k = 0; k < int'(WORDS); k++) begin
      w = img_word(k);
      s = s ^ w[7:0] ^ w[15:8] ^ w[23:16];
    end
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard;
    if (stall) begin
      for (int i = 0; i < 4 && $urandom_range(1, 0) == 1; i++) begin
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = 8'hA5;
        @(negedge clk);
      end
    end
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    guard = 0;
    while (bus.byte_ready_o !== 1'b1 && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    if (bus.byte_ready_o !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL byte_accept_timeout ready=%b required=1", bus.byte_ready_o);
    end
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = 8'hA5;
  endtask

  task automatic send_word(input logic [23:0] w, input bit stall);
    send_byte(w[7:0], stall);
    send_byte(w[15:8], stall);
    send_byte(w[23:16], stall);
  endtask

  task automatic send_words(input int first, input int last, input bit stall);
    for (int k = first; k <= last; k++) send_word(img_word(k), stall);
  endtask

  task automatic start_load();
    wr_addr_q.delete();
    wr_data_q.delete();
    bus.load_start_i = 1'b1;
    start_edge = cyc + 1;
    @(negedge clk);
    bus.load_start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.load_start_i = 1'b0;
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = 8'hA5;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.byte_ready_o, bus.microcode_we_o, bus.core_rst_o, bus.busy_o, bus.done_o, bus.error_o} !== 6'b001000) begin
      n_bad++;
      $display("FAIL reset_flags got=%b required=001000",
               {bus.byte_ready_o, bus.microcode_we_o, bus.core_rst_o, bus.busy_o, bus.done_o, bus.error_o});
    end
    n_cmp++;
    if (bus.microcode_write_addr_o !== 6'd0 || bus.microcode_write_data_o !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_addr_data addr=%h data=%h required=0/0", bus.microcode_write_addr_o, bus.microcode_write_data_o);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.byte_ready_o, bus.busy_o, bus.core_rst_o} !== 3'b001) begin
      n_bad++;
      $display("FAIL idle_after_reset got=%b required=001", {bus.byte_ready_o, bus.busy_o, bus.core_rst_o});
    end
  endtask

  task automatic test_full_load();
    int bad;
    start_load();
    n_cmp++;
    if ({bus.busy_o, bus.byte_ready_o, bus.core_rst_o} !== 3'b111) begin
      n_bad++;
      $display("FAIL full_start_flags got=%b required=111", {bus.busy_o, bus.byte_ready_o, bus.core_rst_o});
    end
    send_words(0, int'(WORDS) - 1, 1'b0);
    n_cmp++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL full_pre_checksum done=%b busy=%b required=0/1", bus.done_o, bus.busy_o);
    end
    send_byte(img_checksum(), 1'b0);
    n_cmp++;
    if ({bus.done_o, bus.core_rst_o, bus.busy_o, bus.error_o} !== 4'b1000) begin
      n_bad++;
      $display("FAIL full_done_flags got=%b required=1000", {bus.done_o, bus.core_rst_o, bus.busy_o, bus.error_o});
    end
    n_cmp++;
    if (cyc - start_edge !== 257) begin
      n_bad++;
      $display("FAIL full_latency edges=%0d required=257", cyc - start_edge);
    end
    n_cmp++;
    if (wr_addr_q.size() !== 64) begin
      n_bad++;
      $display("FAIL full_write_count got=%0d required=64", wr_addr_q.size());
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (i >= wr_addr_q.size()) bad++;
      else if (wr_addr_q[i] !== 6'(i) || wr_data_q[i] !== 19'(img_word(i))) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL full_write_seq bad_entries=%0d required=0", bad);
    end
  endtask

  task automatic test_stall_load();
    int bad;
    start_load();
    n_cmp++;
    if (bus.core_rst_o !== 1'b1 || bus.done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_restart core_rst=%b done=%b required=1/0", bus.core_rst_o, bus.done_o);
    end
    send_words(0, int'(WORDS) - 1, 1'b1);
    send_byte(img_checksum(), 1'b1);
    n_cmp++;
    if (bus.done_o !== 1'b1 || bus.core_rst_o !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_done done=%b core_rst=%b required=1/0", bus.done_o, bus.core_rst_o);
    end
    n_cmp++;
    if (wr_addr_q.size() !== 64) begin
      n_bad++;
      $display("FAIL stall_write_count got=%0d required=64", wr_addr_q.size());
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (i >= wr_addr_q.size()) bad++;
      else if (wr_addr_q[i] !== 6'(i) || wr_data_q[i] !== 19'(img_word(i))) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL stall_write_seq bad_entries=%0d required=0", bad);
    end
  endtask

  task automatic test_reserved_error();
    int bad;
    start_load();
    send_words(0, 4, 1'b0);
    send_word(img_word(5) | 24'h080000, 1'b0);
    n_cmp++;
    if ({bus.error_o, bus.core_rst_o, bus.busy_o, bus.byte_ready_o, bus.microcode_we_o} !== 5'b11000) begin
      n_bad++;
      $display("FAIL rsvd_flags got=%b required=11000",
               {bus.error_o, bus.core_rst_o, bus.busy_o, bus.byte_ready_o, bus.microcode_we_o});
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (wr_addr_q.size() !== 5) begin
      n_bad++;
      $display("FAIL rsvd_write_count got=%0d required=5", wr_addr_q.size());
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i >= wr_addr_q.size()) bad++;
      else if (wr_addr_q[i] !== 6'(i) || wr_data_q[i] !== 19'(img_word(i))) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL rsvd_write_seq bad_entries=%0d required=0", bad);
    end
  endtask

  task automatic test_bad_checksum();
    start_load();
    n_cmp++;
    if (bus.error_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL badsum_start error=%b busy=%b required=0/1", bus.error_o, bus.busy_o);
    end
    send_words(0, int'(WORDS) - 1, 1'b0);
    send_byte(img_checksum() ^ 8'h01, 1'b0);
    n_cmp++;
    if ({bus.error_o, bus.core_rst_o, bus.done_o, bus.busy_o} !== 4'b1100) begin
      n_bad++;
      $display("FAIL badsum_flags got=%b required=1100", {bus.error_o, bus.core_rst_o, bus.done_o, bus.busy_o});
    end
    n_cmp++;
    if (wr_addr_q.size() !== 64) begin
      n_bad++;
      $display("FAIL badsum_write_count got=%0d required=64", wr_addr_q.size());
    end
    start_load();
    send_words(0, int'(WORDS) - 1, 1'b0);
    send_byte(img_checksum(), 1'b0);
    n_cmp++;
    if ({bus.done_o, bus.core_rst_o, bus.error_o} !== 3'b100) begin
      n_bad++;
      $display("FAIL badsum_reload got=%b required=100", {bus.done_o, bus.core_rst_o, bus.error_o});
    end
  endtask

  task automatic test_mid_reset();
    int bad;
    start_load();
    send_words(0, 19, 1'b0);
    send_byte(img_word(20) & 24'hFF, 1'b0);
    send_byte((img_word(20) >> 8) & 24'hFF, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({bus.byte_ready_o, bus.microcode_we_o, bus.core_rst_o, bus.busy_o, bus.done_o, bus.error_o} !== 6'b001000) begin
      n_bad++;
      $display("FAIL midrst_flags got=%b required=001000",
               {bus.byte_ready_o, bus.microcode_we_o, bus.core_rst_o, bus.busy_o, bus.done_o, bus.error_o});
    end
    n_cmp++;
    if (bus.microcode_write_addr_o !== 6'd0 || bus.microcode_write_data_o !== 19'd0) begin
      n_bad++;
      $display("FAIL midrst_addr_data addr=%h data=%h required=0/0", bus.microcode_write_addr_o, bus.microcode_write_data_o);
    end
    @(negedge clk);
    start_load();
    send_words(0, int'(WORDS) - 1, 1'b0);
    send_byte(img_checksum(), 1'b0);
    n_cmp++;
    if (bus.done_o !== 1'b1 || wr_addr_q.size() !== 64) begin
      n_bad++;
      $display("FAIL midrst_reload done=%b writes=%0d required=1/64", bus.done_o, wr_addr_q.size());
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (i >= wr_addr_q.size()) bad++;
      else if (wr_addr_q[i] !== 6'(i) || wr_data_q[i] !== 19'(img_word(i))) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL midrst_write_seq bad_entries=%0d required=0", bad);
    end
  endtask

  task automatic test_start_ignored();
    int bad;
    start_load();
    send_words(0, 9, 1'b0);
    bus.load_start_i = 1'b1;
    send_word(img_word(10), 1'b0);
    bus.load_start_i = 1'b0;
    send_words(11, int'(WORDS) - 1, 1'b0);
    send_byte(img_checksum(), 1'b0);
    n_cmp++;
    if (bus.done_o !== 1'b1 || wr_addr_q.size() !== 64) begin
      n_bad++;
      $display("FAIL ignore_done done=%b writes=%0d required=1/64", bus.done_o, wr_addr_q.size());
    end
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (i >= wr_addr_q.size()) bad++;
      else if (wr_addr_q[i] !== 6'(i) || wr_data_q[i] !== 19'(img_word(i))) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL ignore_write_seq bad_entries=%0d required=0", bad);
    end
    bus.load_start_i = 1'b1;
    @(negedge clk);
    bus.load_start_i = 1'b0;
    n_cmp++;
    if ({bus.core_rst_o, bus.busy_o, bus.done_o, bus.byte_ready_o} !== 4'b1101) begin
      n_bad++;
      $display("FAIL done_restart got=%b required=1101",
               {bus.core_rst_o, bus.busy_o, bus.done_o, bus.byte_ready_o});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_stall_load();
    test_reserved_error();
    test_bad_checksum();
    test_mid_reset();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
